// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler that time-shares one free-running counter among NREQ requesters.
// Optional feature macro COUNTER_SCHED_ABORT_EN: the granted requester may withdraw during CLEAR/RUN.
module counter_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    input  logic [WIDTH-1:0]      value,
    output logic                  cnt_rst_n,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [PW-1:0]    gidx, gidx_n;
    logic [WIDTH-1:0] len_q, len_sel;
    logic [NREQ-1:0]  gnt_n, done_n;
    logic             found;
    logic             abort;
    int               idx;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + PW'(1);
    endfunction

`ifdef COUNTER_SCHED_ABORT_EN
    assign abort = !req[gidx];
`else
    assign abort = 1'b0;
`endif

    // First requesting index at or above ptr, wrapping around
    always_comb begin
        found   = 1'b0;
        gidx_n  = gidx;
        len_sel = len_q;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gidx_n  = PW'(idx);
                len_sel = len[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = gnt;
        done_n  = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = CLEAR;
                    gnt_n   = NREQ'(1) << gidx_n;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = next_ptr(gidx);
                end else if (len_q == '0) begin
                    state_n = DONE;
                    done_n  = gnt;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = next_ptr(gidx);
                end else if (value == len_q - WIDTH'(1)) begin
                    state_n = DONE;
                    done_n  = gnt;
                end
            end
            DONE: begin
                state_n = IDLE;
                gnt_n   = '0;
                ptr_n   = next_ptr(gidx);
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            cnt_rst_n <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            if (state == IDLE && found) gidx <= gidx_n;
            gnt       <= gnt_n;
            done      <= done_n;
            busy      <= (state_n != IDLE);
            cnt_rst_n <= (state_n == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && found) len_q <= len_sel;
    end

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: directed vector table, corner sequences and a randomized
// run against a timeline reference model. Honours COUNTER_SCHED_ABORT_EN when defined.
module tb_counter_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] len = '0;
    logic [WIDTH-1:0]      value;
    logic                  cnt_rst_n;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  r;
        logic [31:0] lv;
        logic [3:0]  eg;
        int          el;
    } vec_t;
    vec_t tbl[6];

    // reference model: granted index (-1 = none), cycles since grant, latched length, pointer
    int m_cur, m_t, m_len, m_ptr;

    counter_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(rst_n), .req(req), .len(len), .value(value),
        .cnt_rst_n(cnt_rst_n), .gnt(gnt), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // shared counter
    always @(posedge clk or negedge cnt_rst_n) begin
        if (!cnt_rst_n) value <= '0;
        else            value <= value + 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string nm, input logic [3:0] r, input logic [31:0] lv,
                           input logic [3:0] eg, input int el);
        int n, d, hi;
        logic [WIDTH-1:0] last;
        req = r;
        len = lv;
        n = 0;
        do begin tick(); n++; end while (gnt == 0 && n < 20);
        chk({nm, "_gnt_lat"}, n, 1);
        chk({nm, "_gnt"}, gnt, eg);
        len = ~lv;
        d = 0; hi = 0; last = '0;
        while (done == 0 && d < 400) begin
            tick();
            d++;
            if (cnt_rst_n) begin hi++; last = value; end
        end
        chk({nm, "_delay"}, d, el + 1);
        chk({nm, "_cnt_hi"}, hi, el);
        chk({nm, "_done"}, done, eg);
        chk({nm, "_gnt_hold"}, gnt, eg);
        if (el > 0) chk({nm, "_last_val"}, last, el - 1);
        req = '0;
        tick();
        chk({nm, "_idle_gnt"}, gnt, 0);
        chk({nm, "_idle_busy"}, busy, 0);
        chk({nm, "_idle_done"}, done, 0);
    endtask

    task automatic model_step();
        int id;
        if (m_cur < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                id = (m_ptr + k) % NREQ;
                if (m_cur < 0 && req[id]) begin
                    m_cur = id;
                    m_len = int'(len[id*WIDTH +: WIDTH]);
                    m_t   = 0;
                end
            end
        end else if (m_t == m_len + 1) begin
            m_ptr = (m_cur + 1) % NREQ;
            m_cur = -1;
        end else begin
            m_t++;
        end
    endtask

    initial begin
        int n, d, c;
        logic [NREQ-1:0] eg, ed;

        tbl[0] = '{4'b0001, 32'h0000_0005, 4'b0001, 5};
        tbl[1] = '{4'b0001, 32'h0000_0000, 4'b0001, 0};
        tbl[2] = '{4'b1001, 32'h0300_0009, 4'b1000, 3};
        tbl[3] = '{4'b0110, 32'h0000_0200, 4'b0010, 2};
        tbl[4] = '{4'b0011, 32'h0000_0401, 4'b0001, 1};
        tbl[5] = '{4'b0100, 32'h00FF_0000, 4'b0100, 255};

        #1 rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt_rst_n", cnt_rst_n, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_one($sformatf("vec%0d", i), tbl[i].r, tbl[i].lv, tbl[i].eg, tbl[i].el);

        // round robin with every requester held
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 4'hF;
        len = 32'h0202_0202;
        for (int j = 0; j < 5; j++) begin
            n = 0;
            do begin tick(); n++; end while (gnt == 0 && n < 20);
            eg = '0; eg[j % NREQ] = 1'b1;
            chk("rr_gnt", gnt, eg);
            d = 0;
            while (done == 0 && d < 20) begin tick(); d++; end
            chk("rr_delay", d, 3);
            chk("rr_done", done, eg);
            tick();
            chk("rr_once", done, 0);
        end
        req = '0;
        tick();

        // reset three cycles into RUN
        req = 4'b0001;
        len = 32'h0000_000A;
        n = 0;
        do begin tick(); n++; end while (gnt == 0 && n < 20);
        chk("mr_gnt", gnt, 4'b0001);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mr_gnt0", gnt, 0);
        chk("mr_done0", done, 0);
        chk("mr_busy0", busy, 0);
        chk("mr_cnt0", cnt_rst_n, 0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_one("mr_after", 4'b0100, 32'h0002_0000, 4'b0100, 2);

        // granted requester drops its request during RUN
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 4'b0110;
        len = 32'h0001_0A00;
        n = 0;
        do begin tick(); n++; end while (gnt == 0 && n < 20);
        chk("ab_gnt", gnt, 4'b0010);
        tick(); tick();
        req = 4'b0100;
`ifdef COUNTER_SCHED_ABORT_EN
        tick();
        chk("ab_idle_gnt", gnt, 0);
        chk("ab_idle_busy", busy, 0);
        chk("ab_idle_done", done, 0);
        chk("ab_idle_cnt", cnt_rst_n, 0);
        tick();
        chk("ab_next_gnt", gnt, 4'b0100);
        d = 0;
        while (done == 0 && d < 50) begin tick(); d++; end
        chk("ab_next_delay", d, 2);
        chk("ab_next_done", done, 4'b0100);
`else
        c = 2;
        while (done == 0 && c < 50) begin tick(); c++; end
        chk("na_delay", c, 11);
        chk("na_done", done, 4'b0010);
        tick();
        chk("na_idle_gnt", gnt, 0);
        tick();
        chk("na_next_gnt", gnt, 4'b0100);
        d = 0;
        while (done == 0 && d < 50) begin tick(); d++; end
        chk("na_next_done", done, 4'b0100);
`endif
        req = '0;
        tick(); tick();

        // randomized traffic against the timeline model
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        m_cur = -1; m_t = 0; m_len = 0; m_ptr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            model_step();
            eg = '0;
            ed = '0;
            if (m_cur >= 0) begin
                eg[m_cur] = 1'b1;
                if (m_t == m_len + 1) ed = eg;
            end
            chk("rnd_gnt", gnt, eg);
            chk("rnd_done", done, ed);
            chk("rnd_busy", busy, (m_cur >= 0) ? 1 : 0);
            chk("rnd_cnt_rst_n", cnt_rst_n, (m_cur >= 0 && m_t >= 1 && m_t <= m_len) ? 1 : 0);
            for (int i = 0; i < NREQ; i++) begin
                if (ed[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    len[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 9));
                end else if ($urandom_range(0, 7) == 0) begin
                    len[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 12));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
